rtype_issue_stage: RTL and testbench

//   Issue/writeback stage directly upstream of the combinational R-type ALU.
//   - Accepts 32-bit MIPS R-type instruction words over a valid/ready handshake.
//   - Reads a 32x32 register file, with bypass, and registers the ALU operands:
//     inA, inB, ALUCode and shamt.
//   - Writes the ALU result back into rd one cycle later.
//   - Together with the ALU this forms a 2-stage R-type pipeline.

---
 rtl/rtype_issue_stage_if.sv | 44 ++++
 rtl/rtype_issue_stage.sv | 210 +++++++++++++++++++++
 tb/tb_rtype_issue_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtype_issue_stage_if.sv
// Instruction handshake and ALU operand/result bundle for the R-type issue stage.
// The master side is the instruction source together with the combinational ALU.
// The slave side is the issue stage itself.
interface rtype_issue_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        hold;
    logic [31:0] alu_inA;
    logic [31:0] alu_inB;
    logic [5:0]  alu_code;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    modport master (
        output instr_valid,
        output instr,
        output hold,
        output alu_result,
        input  instr_ready,
        input  alu_inA,
        input  alu_inB,
        input  alu_code,
        input  alu_shamt,
        input  wb_valid,
        input  wb_addr
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  hold,
        input  alu_result,
        output instr_ready,
        output alu_inA,
        output alu_inB,
        output alu_code,
        output alu_shamt,
        output wb_valid,
        output wb_addr
    );
endinterface

// File: rtl/rtype_issue_stage.sv
// R-type issue/writeback stage in front of a combinational ALU.
// It decodes an accepted instruction word and reads the 32x32 register file.
// The in-flight ALU result is bypassed so dependent ops can issue back-to-back.
// It registers the ALU operands. The ALU result is written back one cycle later.
module rtype_issue_stage #(
    parameter int CNT_W    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    rtype_issue_stage_if.slave bus,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired,
    input  logic [4:0]         dbg_addr,
    output logic [31:0]        dbg_data
);

    localparam logic [5:0] FN_SLL      = 6'h00;
    localparam logic [5:0] FN_SRL      = 6'h02;
    localparam logic [5:0] FN_SRA      = 6'h03;
    localparam logic [5:0] FN_ADD      = 6'h20;
    localparam logic [5:0] FN_SUB      = 6'h22;
    localparam logic [5:0] FN_AND      = 6'h24;
    localparam logic [5:0] FN_OR       = 6'h25;
    localparam logic [5:0] CODE_ILLEGAL = 6'h3F;

    // Shift ops take their operand from rt and the amount from the shamt field.
    function automatic logic f_is_shift(input logic [5:0] funct);
        logic r;
        case (funct)
            FN_SLL, FN_SRL, FN_SRA: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Only R-type (op==0) words with a supported funct are executed.
    function automatic logic f_is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        if (op != 6'd0) begin
            r = 1'b0;
        end else begin
            case (funct)
                FN_SLL, FN_SRL, FN_SRA,
                FN_ADD, FN_SUB, FN_AND, FN_OR: r = 1'b1;
                default:                       r = 1'b0;
            endcase
        end
        return r;
    endfunction

    // The op in EX has not reached the regfile yet, so its result is forwarded.
    // Register 0 is never forwarded.
    function automatic logic [31:0] f_bypass(
        input logic [4:0]  addr,
        input logic [31:0] reg_val,
        input logic        wb_v,
        input logic [4:0]  wb_a,
        input logic [31:0] result
    );
        logic [31:0] r;
        if (wb_v && (addr == wb_a) && (addr != 5'd0)) begin
            r = result;
        end else begin
            r = reg_val;
        end
        return r;
    endfunction

    // Architectural state
    logic [31:0]      regs_r [32];
    logic [31:0]      alu_ina_r;
    logic [31:0]      alu_inb_r;
    logic [5:0]       alu_code_r;
    logic [4:0]       alu_shamt_r;
    logic             wb_valid_r;
    logic [4:0]       wb_addr_r;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;

    // Decode of the presented instruction word
    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  shamt_s;
    logic [5:0]  funct_s;
    logic        accept_s;
    logic        legal_s;
    logic        shift_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic [31:0] nxt_ina_s;
    logic [31:0] nxt_inb_s;
    logic [5:0]  nxt_code_s;
    logic [4:0]  nxt_shamt_s;
    logic        wr_en_s;

    assign op_s    = bus.instr[31:26];
    assign rs_s    = bus.instr[25:21];
    assign rt_s    = bus.instr[20:16];
    assign rd_s    = bus.instr[15:11];
    assign shamt_s = bus.instr[10:6];
    assign funct_s = bus.instr[5:0];

    // Hold only gates acceptance; the op already in EX is unaffected.
    assign bus.instr_ready = ~bus.hold;
    assign accept_s        = bus.instr_valid & ~bus.hold;

    // Classify the instruction and read both sources with bypass.
    always_comb begin
        legal_s  = f_is_legal(op_s, funct_s);
        shift_s  = f_is_shift(funct_s);
        rs_val_s = f_bypass(rs_s, regs_r[rs_s], wb_valid_r, wb_addr_r, bus.alu_result);
        rt_val_s = f_bypass(rt_s, regs_r[rt_s], wb_valid_r, wb_addr_r, bus.alu_result);
    end

    // Select the operand values to be loaded into EX.
    always_comb begin
        nxt_ina_s   = 32'd0;
        nxt_inb_s   = 32'd0;
        nxt_shamt_s = 5'd0;
        nxt_code_s  = CODE_ILLEGAL;
        if (shift_s) begin
            nxt_ina_s   = rt_val_s;
            nxt_inb_s   = 32'd0;
            nxt_shamt_s = shamt_s;
        end else begin
            nxt_ina_s   = rs_val_s;
            nxt_inb_s   = rt_val_s;
            nxt_shamt_s = 5'd0;
        end
        if (legal_s) begin
            nxt_code_s = funct_s;
        end else begin
            nxt_code_s = CODE_ILLEGAL;
        end
    end

    // Writes go to the regfile only for legal ops in EX.
    // A write to register 0 is suppressed when it is hardwired.
    always_comb begin
        wr_en_s = 1'b0;
        if (wb_valid_r && !(ZERO_REG && (wb_addr_r == 5'd0))) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register file: cleared on reset, written with the ALU result of the EX op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[wb_addr_r] <= bus.alu_result;
        end
    end

    // EX register: it loads on accept. On idle cycles it drops wb_valid and keeps the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ina_r   <= 32'd0;
            alu_inb_r   <= 32'd0;
            alu_code_r  <= 6'd0;
            alu_shamt_r <= 5'd0;
            wb_valid_r  <= 1'b0;
            wb_addr_r   <= 5'd0;
        end else if (accept_s) begin
            alu_ina_r   <= nxt_ina_s;
            alu_inb_r   <= nxt_inb_s;
            alu_code_r  <= nxt_code_s;
            alu_shamt_r <= nxt_shamt_s;
            wb_valid_r  <= legal_s;
            wb_addr_r   <= rd_s;
        end else begin
            wb_valid_r  <= 1'b0;
        end
    end

    // Status: sticky illegal flag and the wrapping count of retired ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && !legal_s) begin
                illegal_r <= 1'b1;
            end
            if (wb_valid_r) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.alu_inA   = alu_ina_r;
    assign bus.alu_inB   = alu_inb_r;
    assign bus.alu_code  = alu_code_r;
    assign bus.alu_shamt = alu_shamt_r;
    assign bus.wb_valid  = wb_valid_r;
    assign bus.wb_addr   = wb_addr_r;
    assign illegal       = illegal_r;
    assign retired       = retired_r;

    // Debug port reads the regfile directly. A same-cycle write is not yet visible.
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: tb/tb_rtype_issue_stage.sv
// Bench for rtype_issue_stage: a bench-side ALU, an architectural reference model and a scoreboard.
module tb_rtype_issue_stage;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [4:0]       dbg_addr;
    logic [31:0]      dbg_data;
    logic             poke_en;
    logic [31:0]      poke_val;

    int tests = 0;
    int failed = 0;

    rtype_issue_stage_if bus_if();

    rtype_issue_stage #(.CNT_W(CNT_W), .ZERO_REG(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .illegal  (illegal),
        .retired  (retired),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] code, input logic [4:0] sh);
        case (code)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h00:   return a << sh;
            6'h02:   return a >> sh;
            6'h03:   return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    // Bench-side combinational ALU. A poke can override it to preload registers.
    always_comb begin
        if (poke_en) bus_if.alu_result = poke_val;
        else bus_if.alu_result = alu_f(bus_if.alu_inA, bus_if.alu_inB, bus_if.alu_code, bus_if.alu_shamt);
    end

    // Architectural model: registers after every issued instruction, in program order
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  code;
        logic [4:0]  sh;
        logic        wv;
        logic [4:0]  wa;
    } exp_t;

    logic [31:0] m [32];
    int          m_ret;
    logic        m_ill;
    exp_t        q[$];

    function automatic logic [31:0] rt_f(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_issue(input logic [31:0] w, input bit use_poke, input logic [31:0] pv);
        exp_t        e;
        logic [5:0]  fn;
        logic        legal;
        logic [31:0] res;
        fn    = w[5:0];
        legal = (w[31:26] == 6'd0) &&
                (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03});
        if (fn inside {6'h00, 6'h02, 6'h03}) begin
            e.a = m[w[20:16]]; e.b = 32'd0; e.sh = w[10:6];
        end else begin
            e.a = m[w[25:21]]; e.b = m[w[20:16]]; e.sh = 5'd0;
        end
        e.code = legal ? fn : 6'h3F;
        e.wv   = legal;
        e.wa   = w[15:11];
        q.push_back(e);
        if (legal) begin
            res = use_poke ? pv : alu_f(e.a, e.b, e.code, e.sh);
            if (w[15:11] != 5'd0) m[w[15:11]] = res;
            m_ret++;
        end else begin
            m_ill = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m_ret = 0;
        m_ill = 1'b0;
    endtask

    // Called at a negedge. The instruction is accepted at the next posedge.
    task automatic drive_issue(input logic [31:0] w);
        bus_if.instr = w; bus_if.instr_valid = 1'b1; bus_if.hold = 1'b0;
        model_issue(w, 1'b0, 32'd0);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
    endtask

    // ADD rd = R0 + R0 with the ALU result overridden to v while it sits in EX.
    task automatic preload(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] w;
        w = rt_f(5'd0, 5'd0, rd, 5'd0, 6'h20);
        bus_if.instr = w; bus_if.instr_valid = 1'b1; bus_if.hold = 1'b0;
        model_issue(w, 1'b1, v);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        poke_val = v; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_if.instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1 chk($sformatf("dbg_R%0d", i), dbg_data, m[i]);
        end
    endtask

    task automatic chk_status();
        chk("retired", 32'(retired), 32'(m_ret % (1 << CNT_W)));
        chk("illegal", 32'(illegal), 32'(m_ill));
    endtask

    // Monitor: each accept seen at a posedge is checked against the next queued expectation.
    initial begin
        logic hs;
        exp_t e;
        forever begin
            @(posedge clk);
            hs = rst_n && bus_if.instr_valid && bus_if.instr_ready;
            @(negedge clk);
            if (hs) begin
                if (q.size() == 0) begin
                    chk("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("alu_inA",   bus_if.alu_inA, e.a);
                    chk("alu_inB",   bus_if.alu_inB, e.b);
                    chk("alu_code",  32'(bus_if.alu_code), 32'(e.code));
                    chk("alu_shamt", 32'(bus_if.alu_shamt), 32'(e.sh));
                    chk("wb_valid",  32'(bus_if.wb_valid), 32'(e.wv));
                    chk("wb_addr",   32'(bus_if.wb_addr), 32'(e.wa));
                end
            end else begin
                chk("idle_wb_valid", 32'(bus_if.wb_valid), 32'd0);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [5:0]  lf [7];
        logic [31:0] w;
        logic        v;
        logic        h;
        lf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h03};
        bus_if.instr_valid = 1'b0;
        bus_if.instr = 32'd0;
        bus_if.hold = 1'b0;
        poke_en = 1'b0;
        poke_val = 32'd0;
        dbg_addr = 5'd0;
        model_reset();

        // Reset values appear before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_inA", bus_if.alu_inA, 32'd0);
        chk("rst_inB", bus_if.alu_inB, 32'd0);
        chk("rst_code", 32'(bus_if.alu_code), 32'd0);
        chk("rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: ADD R3 = R1 + R2, with R1=5 and R2=7.
        // Test 2: SUB R4 = R3 - R3 issued back-to-back, relying on the bypass.
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        drive_issue(rt_f(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        drive_issue(rt_f(5'd3, 5'd3, 5'd4, 5'd0, 6'h22));
        idle(2);
        dbg_addr = 5'd3; #1 chk("add_R3", dbg_data, 32'd12);
        dbg_addr = 5'd4; #1 chk("sub_R4", dbg_data, 32'd0);
        chk_status();

        // Test 3: SRA R6 = R5 >>> 4
        @(negedge clk);
        preload(5'd5, 32'h8000_0000);
        drive_issue(rt_f(5'd0, 5'd5, 5'd6, 5'd4, 6'h03));
        idle(2);
        dbg_addr = 5'd6; #1 chk("sra_R6", dbg_data, 32'hF800_0000);

        // Test 4: illegal funct and illegal op
        @(negedge clk);
        drive_issue(rt_f(5'd1, 5'd2, 5'd7, 5'd0, 6'h2A));
        drive_issue({6'h08, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20});
        idle(2);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk_regs();
        chk_status();

        // Test 5: hold for 3 cycles while an op is still in flight
        @(negedge clk);
        drive_issue(rt_f(5'd1, 5'd2, 5'd10, 5'd0, 6'h20));
        bus_if.instr = rt_f(5'd10, 5'd1, 5'd11, 5'd0, 6'h20);
        bus_if.instr_valid = 1'b1;
        bus_if.hold = 1'b1;
        repeat (3) begin
            #1 chk("ready_held", 32'(bus_if.instr_ready), 32'd0);
            @(negedge clk);
        end
        bus_if.hold = 1'b0;
        #1 chk("ready_released", 32'(bus_if.instr_ready), 32'd1);
        model_issue(bus_if.instr, 1'b0, 32'd0);
        @(negedge clk);
        idle(2);
        dbg_addr = 5'd10; #1 chk("hold_R10", dbg_data, 32'd12);
        dbg_addr = 5'd11; #1 chk("hold_R11", dbg_data, 32'd17);
        chk_status();

        // Test 7: a write to R0 is dropped but still retires. The counter then wraps.
        @(negedge clk);
        drive_issue(rt_f(5'd1, 5'd2, 5'd0, 5'd0, 6'h20));
        idle(2);
        dbg_addr = 5'd0; #1 chk("r0_zero", dbg_data, 32'd0);
        chk_status();
        @(negedge clk);
        while ((m_ret % (1 << CNT_W)) != 0) drive_issue(rt_f(5'd1, 5'd2, 5'd12, 5'd0, 6'h24));
        idle(2);
        chk("retired_wrap", 32'(retired), 32'd0);
        chk_status();

        // Test 6: reset is asserted while an op sits in EX.
        @(negedge clk);
        drive_issue(rt_f(5'd1, 5'd2, 5'd9, 5'd0, 6'h20));
        poke_val = 32'hDEAD_BEEF; poke_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_inA", bus_if.alu_inA, 32'd0);
        chk("mid_rst_inB", bus_if.alu_inB, 32'd0);
        chk("mid_rst_code", 32'(bus_if.alu_code), 32'd0);
        chk("mid_rst_shamt", 32'(bus_if.alu_shamt), 32'd0);
        chk("mid_rst_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        chk("mid_rst_wb_addr", 32'(bus_if.wb_addr), 32'd0);
        chk("mid_rst_illegal", 32'(illegal), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        model_reset();
        @(negedge clk);
        poke_en = 1'b0;
        rst_n = 1'b1;
        idle(2);
        chk_regs();

        // Random phase: mostly legal ops on a small register window, some illegal words, random hold.
        @(negedge clk);
        for (int i = 1; i < 8; i++) preload(i[4:0], $urandom);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom;
            end else begin
                w = rt_f(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                         lf[$urandom_range(0, 6)]);
            end
            v = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            bus_if.instr = w;
            bus_if.instr_valid = v;
            bus_if.hold = h;
            if (v && !h) model_issue(w, 1'b0, 32'd0);
            @(negedge clk);
        end
        idle(2);
        chk_regs();
        chk_status();
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
